// File: rtl/game_pkg.sv
// Shared state codes, judgement codes and helpers for the
// factorization game judge / HP bookkeeping unit.
package game_pkg;

    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam logic [3:0] ST_DRAW     = 4'b0110;
    localparam logic [3:0] ST_WRONG    = 4'b0111;
    localparam logic [3:0] ST_GOOD     = 4'b1000;
    localparam logic [3:0] ST_OUCH     = 4'b1001;
    localparam logic [3:0] ST_WIN      = 4'b1010;
    localparam logic [3:0] ST_LOSE     = 4'b1011;

    typedef enum logic [1:0] {
        JUDG_NONE  = 2'b00,
        JUDG_LOCAL = 2'b01,
        JUDG_OPP   = 2'b10,
        JUDG_DRAW  = 2'b11
    } judg_t;

    localparam logic [1:0] HPS_OK       = 2'b00;
    localparam logic [1:0] HPS_OPP_DEAD = 2'b01;
    localparam logic [1:0] HPS_MY_DEAD  = 2'b10;

    typedef enum logic [2:0] {
        F_IDLE,
        F_ARMED,
        F_MUL,
        F_CMP,
        F_DECIDE,
        F_HOLD
    } jfsm_t;

    function automatic logic is_timed(input logic [3:0] s);
        return (s == ST_WRONG) || (s == ST_GOOD) || (s == ST_OUCH) ||
               (s == ST_DRAW)  || (s == ST_WIN)  || (s == ST_LOSE);
    endfunction

    function automatic logic is_end(input logic [3:0] s);
        return (s == ST_WIN) || (s == ST_LOSE);
    endfunction

endpackage

// File: rtl/sec_timer.sv
// State-duration timer: restarts on any STATE change, fires one
// TMO pulse after ONE_SEC cycles in a timed state, then holds.
module sec_timer
    import game_pkg::*;
#(
    parameter int ONE_SEC = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] STATE,
    output logic       TMO
);

    localparam int CW = $clog2(ONE_SEC);
    localparam logic [CW-1:0] LAST = CW'(ONE_SEC - 1);
    localparam logic [CW-1:0] PRE  = CW'(ONE_SEC - 2);

    logic [3:0]    st_q;
    logic [CW-1:0] cnt;
    logic          run;

    assign run = is_timed(STATE) && (STATE == st_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q <= 4'b0000;
            cnt  <= '0;
            TMO  <= 1'b0;
        end else begin
            st_q <= STATE;
            TMO  <= run && (cnt == PRE);
            if (!run)
                cnt <= '0;
            else if (cnt != LAST)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/judge_hp_unit.sv
// Answer judge, HP bookkeeper and state timer beside the game
// control FSM; arbitrates local answers against opponent strobes.
module judge_hp_unit
    import game_pkg::*;
#(
    parameter int QW      = 10,
    parameter int FW      = 5,
    parameter int HP_MAX  = 3,
    parameter int ONE_SEC = 50_000_000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [3:0]    STATE,
    input  logic [QW-1:0] QUE_VAL,
    input  logic          QUE_LD,
    input  logic [FW-1:0] ANS_A,
    input  logic [FW-1:0] ANS_B,
    input  logic          ANS_STB,
    input  logic          OPP_OK,
    output logic          QUE,
    output logic [1:0]    JUDG_OUT,
    output logic          WRONG_OUT,
    output logic [1:0]    HP_OUT,
    output logic [1:0]    MY_HP,
    output logic [1:0]    OPP_HP,
    output logic          TMO_OUT
);

    localparam int PW = 2 * FW;
    localparam logic [1:0] HP_INIT = 2'(HP_MAX);

    jfsm_t         cur, nxt;
    logic          que_q;
    logic [QW-1:0] q_reg;
    logic [FW-1:0] a_q, b_q;
    logic [PW-1:0] prod_q;
    logic [QW-1:0] prod_fit;
    logic          loc_ok;
    logic          opp_flag;
    judg_t         judg_q, judg_nx;
    logic          wrong_q;
    logic [1:0]    my_hp, opp_hp;
    logic          tmo;

    logic ld_ab, ld_prod, dec_go, wrong_go;
    logic hold_done, opp_cap, opp_eff, from_cmp;

    generate
        if (PW >= QW) begin : g_trunc
            assign prod_fit = prod_q[QW-1:0];
        end else begin : g_ext
            assign prod_fit = {{(QW-PW){1'b0}}, prod_q};
        end
    endgenerate

    // Trivial factorizations (1 x N) never count as a solution.
    assign loc_ok = (prod_fit == q_reg) &&
                    (a_q >= FW'(2)) && (b_q >= FW'(2));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cur <= F_IDLE;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            F_IDLE:   if (que_q) nxt = F_ARMED;
            F_ARMED: begin
                if (opp_flag)
                    nxt = F_DECIDE;
                else if (ANS_STB && (STATE == ST_INPUT))
                    nxt = F_MUL;
            end
            F_MUL:    nxt = F_CMP;
            F_CMP:    nxt = loc_ok ? F_DECIDE : F_ARMED;
            F_DECIDE: nxt = F_HOLD;
            F_HOLD:   if (STATE == ST_READY) nxt = F_IDLE;
            default:  nxt = F_IDLE;
        endcase
    end

    always_comb begin
        ld_ab     = (cur == F_ARMED) && !opp_flag &&
                    ANS_STB && (STATE == ST_INPUT);
        ld_prod   = (cur == F_MUL);
        from_cmp  = (cur == F_CMP) && loc_ok;
        dec_go    = from_cmp || ((cur == F_ARMED) && opp_flag);
        wrong_go  = (cur == F_CMP) && !loc_ok;
        hold_done = (cur == F_HOLD) && (STATE == ST_READY);
        opp_cap   = OPP_OK && ((cur == F_ARMED) ||
                               (cur == F_MUL) || (cur == F_CMP));
        opp_eff   = opp_flag || opp_cap;
    end

    // Code bits line up as {opponent, local}: 01 win, 10 loss, 11 draw.
    assign judg_nx = judg_t'({opp_eff, from_cmp});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            que_q    <= 1'b0;
            q_reg    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            opp_flag <= 1'b0;
            judg_q   <= JUDG_NONE;
            wrong_q  <= 1'b0;
        end else begin
            if (QUE_LD) begin
                que_q <= 1'b1;
                q_reg <= QUE_VAL;
            end else if (dec_go) begin
                que_q <= 1'b0;
            end
            if (ld_ab) begin
                a_q <= ANS_A;
                b_q <= ANS_B;
            end
            if (ld_prod)
                prod_q <= PW'(a_q) * PW'(b_q);
            if (dec_go)
                opp_flag <= 1'b0;
            else if (opp_cap)
                opp_flag <= 1'b1;
            if (dec_go)
                judg_q <= judg_nx;
            else if (hold_done)
                judg_q <= JUDG_NONE;
            wrong_q <= wrong_go;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            my_hp  <= HP_INIT;
            opp_hp <= HP_INIT;
        end else if (tmo && is_end(STATE)) begin
            my_hp  <= HP_INIT;
            opp_hp <= HP_INIT;
        end else if (dec_go) begin
            unique case (judg_nx)
                JUDG_LOCAL: if (opp_hp != 2'd0) opp_hp <= opp_hp - 2'd1;
                JUDG_OPP:   if (my_hp != 2'd0) my_hp <= my_hp - 2'd1;
                default: ;
            endcase
        end
    end

    sec_timer #(
        .ONE_SEC(ONE_SEC)
    ) u_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .STATE(STATE),
        .TMO  (tmo)
    );

    always_comb begin
        HP_OUT = HPS_OK;
        if (opp_hp == 2'd0)
            HP_OUT = HPS_OPP_DEAD;
        else if (my_hp == 2'd0)
            HP_OUT = HPS_MY_DEAD;
    end

    assign QUE       = que_q;
    assign JUDG_OUT  = judg_q;
    assign WRONG_OUT = wrong_q;
    assign MY_HP     = my_hp;
    assign OPP_HP    = opp_hp;
    assign TMO_OUT   = tmo;

endmodule

// File: tb/tb_judge_hp_unit.sv
// Directed bench for judge_hp_unit with a shortened timeout.
module tb_judge_hp_unit;
    import game_pkg::*;

    localparam int QW = 10;
    localparam int FW = 5;

    logic          CLK;
    logic          RST_N;
    logic [3:0]    STATE;
    logic [QW-1:0] QUE_VAL;
    logic          QUE_LD;
    logic [FW-1:0] ANS_A, ANS_B;
    logic          ANS_STB, OPP_OK;
    logic          QUE, WRONG_OUT, TMO_OUT;
    logic [1:0]    JUDG_OUT, HP_OUT, MY_HP, OPP_HP;

    int n_total = 0;
    int n_fail  = 0;
    int p, at;
    logic bad;
    logic [1:0] exp_hp [4];

    judge_hp_unit #(
        .QW(QW), .FW(FW), .HP_MAX(3), .ONE_SEC(8)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .STATE(STATE),
        .QUE_VAL(QUE_VAL), .QUE_LD(QUE_LD),
        .ANS_A(ANS_A), .ANS_B(ANS_B), .ANS_STB(ANS_STB),
        .OPP_OK(OPP_OK), .QUE(QUE), .JUDG_OUT(JUDG_OUT),
        .WRONG_OUT(WRONG_OUT), .HP_OUT(HP_OUT), .MY_HP(MY_HP),
        .OPP_HP(OPP_HP), .TMO_OUT(TMO_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_q(input logic [QW-1:0] v);
        QUE_VAL = v;
        QUE_LD  = 1'b1;
        tick();
        QUE_LD  = 1'b0;
        tick();
    endtask

    task automatic answer(input logic [FW-1:0] a, input logic [FW-1:0] b);
        ANS_A   = a;
        ANS_B   = b;
        ANS_STB = 1'b1;
        tick();
        ANS_STB = 1'b0;
    endtask

    task automatic ack();
        STATE = ST_READY;
        tick();
        tick();
    endtask

    task automatic run_timed(input logic [3:0] st, input int n,
                             output int pulses, output int when);
        STATE  = st;
        pulses = 0;
        when   = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (TMO_OUT) begin
                pulses++;
                when = i;
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; STATE = ST_READY; QUE_VAL = '0; QUE_LD = 1'b0;
        ANS_A = '0; ANS_B = '0; ANS_STB = 1'b0; OPP_OK = 1'b0;
        exp_hp = '{2'd2, 2'd1, 2'd0, 2'd0};
        tick();
        tick();
        chk("rst_que", QUE, 0);
        chk("rst_judg", JUDG_OUT, 0);
        chk("rst_wrong", WRONG_OUT, 0);
        chk("rst_tmo", TMO_OUT, 0);
        chk("rst_hpout", HP_OUT, 0);
        chk("rst_myhp", MY_HP, 3);
        chk("rst_opphp", OPP_HP, 3);
        RST_N = 1'b1;
        tick();

        // local win, with a question reload while armed
        load_q(10'd35);
        chk("que_set", QUE, 1);
        load_q(10'd91);
        STATE = ST_INPUT;
        answer(5'd7, 5'd13);
        tick();
        chk("win_judg_early", JUDG_OUT, 0);
        tick();
        chk("win_judg", JUDG_OUT, 1);
        chk("win_opphp", OPP_HP, 2);
        chk("win_myhp", MY_HP, 3);
        chk("win_que", QUE, 0);
        chk("win_hpout", HP_OUT, 0);
        tick();
        chk("hold_judg", JUDG_OUT, 1);
        ack();
        chk("ack_judg", JUDG_OUT, 0);

        // answer outside INPUT is ignored
        load_q(10'd91);
        STATE = ST_QUESTION;
        answer(5'd7, 5'd13);
        tick();
        tick();
        chk("ign_wrong", WRONG_OUT, 0);
        chk("ign_judg", JUDG_OUT, 0);

        // 1 x N is rejected even when the product matches
        STATE = ST_INPUT;
        load_q(10'd29);
        answer(5'd1, 5'd29);
        tick();
        chk("wrong_early", WRONG_OUT, 0);
        tick();
        chk("wrong_pulse", WRONG_OUT, 1);
        chk("wrong_judg", JUDG_OUT, 0);
        tick();
        chk("wrong_end", WRONG_OUT, 0);
        load_q(10'd91);
        answer(5'd13, 5'd7);
        tick();
        tick();
        chk("retry_judg", JUDG_OUT, 1);
        chk("retry_opphp", OPP_HP, 1);
        ack();

        // opponent correct during MUL -> draw
        load_q(10'd91);
        STATE = ST_INPUT;
        answer(5'd7, 5'd13);
        OPP_OK = 1'b1;
        tick();
        OPP_OK = 1'b0;
        tick();
        chk("draw_judg", JUDG_OUT, 3);
        chk("draw_myhp", MY_HP, 3);
        chk("draw_opphp", OPP_HP, 1);
        ack();

        // opponent HP to zero, then WIN timeout reloads
        load_q(10'd91);
        STATE = ST_INPUT;
        answer(5'd7, 5'd13);
        tick();
        tick();
        chk("kill_opphp", OPP_HP, 0);
        chk("kill_hpout", HP_OUT, 1);
        ack();
        run_timed(ST_WIN, 12, p, at);
        chk("win_tmo_cnt", p, 1);
        chk("win_tmo_at", at, 8);
        chk("win_reload_opp", OPP_HP, 3);
        chk("win_reload_my", MY_HP, 3);

        // opponent-only rounds drain own HP, saturating at 0
        for (int r = 0; r < 4; r++) begin
            load_q(10'd91);
            OPP_OK = 1'b1;
            tick();
            OPP_OK = 1'b0;
            tick();
            chk($sformatf("opp_judg_r%0d", r), JUDG_OUT, 2);
            chk($sformatf("opp_myhp_r%0d", r), MY_HP, exp_hp[r]);
            ack();
        end
        chk("lose_hpout", HP_OUT, 2);
        run_timed(ST_LOSE, 12, p, at);
        chk("lose_tmo_cnt", p, 1);
        chk("lose_reload_my", MY_HP, 3);
        chk("lose_hpout_clr", HP_OUT, 0);

        // timer: single pulse, and restart on STATE change
        run_timed(ST_GOOD, 20, p, at);
        chk("good_tmo_cnt", p, 1);
        chk("good_tmo_at", at, 8);
        STATE = ST_READY;
        tick();
        STATE = ST_GOOD;
        p = 0;
        at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (TMO_OUT) begin
                p++;
                at = i;
            end
            if (i == 5) STATE = ST_READY;
            if (i == 6) STATE = ST_GOOD;
        end
        chk("restart_tmo_cnt", p, 1);
        chk("restart_tmo_at", at, 14);

        // reset in the middle of an evaluation
        STATE = ST_READY;
        tick();
        load_q(10'd91);
        OPP_OK = 1'b1;
        tick();
        OPP_OK = 1'b0;
        tick();
        chk("pre_rst_myhp", MY_HP, 2);
        ack();
        load_q(10'd91);
        STATE = ST_INPUT;
        answer(5'd7, 5'd13);
        RST_N = 1'b0;
        #1;
        chk("mrst_que", QUE, 0);
        chk("mrst_judg", JUDG_OUT, 0);
        chk("mrst_myhp", MY_HP, 3);
        chk("mrst_opphp", OPP_HP, 3);
        tick();
        RST_N = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (WRONG_OUT || (JUDG_OUT != 2'b00) || QUE) bad = 1'b1;
        end
        chk("mrst_quiet", bad, 0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
